// File: rtl/store_queue_pkg.sv
// ---------------------------------------------------------------------------
// store_queue_pkg : store-mode codes and shared helpers for the store queue
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package store_queue_pkg;

   localparam logic [2:0] SL_WORD      = 3'd0;
   localparam logic [2:0] SL_HALF      = 3'd1;
   localparam logic [2:0] SL_BYTE      = 3'd2;
   localparam logic [2:0] SL_WORDLEFT  = 3'd3;
   localparam logic [2:0] SL_WORDRIGHT = 3'd4;

   localparam int SQ_MAXDW = 64;

   function automatic logic is_store_mode(input logic [2:0] mode);
      return (mode == SL_WORD) || (mode == SL_HALF) || (mode == SL_BYTE) ||
             (mode == SL_WORDLEFT) || (mode == SL_WORDRIGHT);
   endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_align.sv
// ---------------------------------------------------------------------------
// store_lane_align : aligns a 32-bit store into one word lane with byte enables
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_lane_align
   import store_queue_pkg::*;
(
   input  logic [2:0]  mode,
   input  logic [1:0]  sub,
   input  logic [31:0] data,
   output logic [31:0] aligned_data,
   output logic [3:0]  be,
   output logic        misalign
);

   always_comb begin
      aligned_data = '0;
      be           = '0;
      misalign     = 1'b0;
      case (mode)
         SL_WORD: begin
            aligned_data = data;
            be           = 4'b1111;
            misalign     = (sub != 2'd0);
         end
         SL_HALF: begin
            aligned_data = data << {sub[1], 4'b0000};
            be           = 4'b0011 << {sub[1], 1'b0};
            misalign     = sub[0];
         end
         SL_BYTE: begin
            aligned_data = data << {sub, 3'b000};
            be           = 4'b0001 << sub;
         end
         // 3-sub on a 2-bit offset is simply its complement
         SL_WORDLEFT: begin
            aligned_data = data >> {~sub, 3'b000};
            be           = 4'b1111 >> ~sub;
         end
         SL_WORDRIGHT: begin
            aligned_data = data << {sub, 3'b000};
            be           = 4'b1111 << sub;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/store_queue.sv
// ---------------------------------------------------------------------------
// store_queue : aligned, coalescing store FIFO draining over valid/ready
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_queue
   import store_queue_pkg::*;
#(
   parameter int DW       = 32,
   parameter int AW       = 32,
   parameter int DEPTH    = 4,
   parameter int COALESCE = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_addr,
   input  logic [31:0]              in_data,
   input  logic [2:0]               in_mode,
   output logic                     ades,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [AW-1:0]            m_addr,
   output logic [DW-1:0]            m_data,
   output logic [DW/8-1:0]          m_be,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int BW   = DW / 8;
   localparam int OFFW = $clog2(BW);
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   logic [31:0]   lane_data;
   logic [3:0]    lane_be;
   logic          misalign;
   logic [DW-1:0] new_data;
   logic [BW-1:0] new_be;
   logic [AW-1:0] new_addr;

   store_lane_align u_align (
      .mode         (in_mode),
      .sub          (in_addr[1:0]),
      .data         (in_data),
      .aligned_data (lane_data),
      .be           (lane_be),
      .misalign     (misalign)
   );

   generate
      if (DW == SQ_MAXDW) begin : g_lane64
         assign new_data = in_addr[2] ? {lane_data, 32'h0} : {32'h0, lane_data};
         assign new_be   = in_addr[2] ? {lane_be, 4'h0}    : {4'h0, lane_be};
      end else begin : g_lane32
         assign new_data = lane_data;
         assign new_be   = lane_be;
      end
   endgenerate

   assign new_addr = {in_addr[AW-1:OFFW], {OFFW{1'b0}}};

   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [BW-1:0] be_mem   [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] tail_last;
   logic [CW-1:0] count_r;

   logic          legal_mode;
   logic          push;
   logic          pop;
   logic          merge;
   logic          append;
   logic [DW-1:0] merged_data;

   assign empty      = (count_r == '0);
   assign full       = (count_r == FULL_CNT);
   assign in_ready   = !full;
   assign count      = count_r;
   assign tail_last  = tail - 1'b1;
   assign legal_mode = is_store_mode(in_mode);
   assign ades       = in_valid && misalign;
   assign push       = in_valid && !full && legal_mode && !misalign;
   assign pop        = !empty && m_ready;

   // Never merge into the head while it is leaving, or the new bytes are lost.
   assign merge  = (COALESCE != 0) && !empty && (addr_mem[tail_last] == new_addr) &&
                   !((count_r == ONE_CNT) && pop);
   assign append = push && !merge;

   always_comb begin
      merged_data = data_mem[tail_last];
      for (int b = 0; b < BW; b++) begin
         if (new_be[b]) merged_data[8*b +: 8] = new_data[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count_r <= '0;
      end else begin
         if (append) tail <= tail + 1'b1;
         if (pop)    head <= head + 1'b1;
         case ({append, pop})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push) begin
         if (merge) begin
            data_mem[tail_last] <= merged_data;
            be_mem[tail_last]   <= be_mem[tail_last] | new_be;
         end else begin
            addr_mem[tail] <= new_addr;
            data_mem[tail] <= new_data;
            be_mem[tail]   <= new_be;
         end
      end
   end

   assign m_valid = !empty;
   assign m_addr  = empty ? '0 : addr_mem[head];
   assign m_data  = empty ? '0 : data_mem[head];
   assign m_be    = empty ? '0 : be_mem[head];

endmodule

`default_nettype wire

// File: tb/tb_store_queue.sv
// ---------------------------------------------------------------------------
// tb_store_queue : directed checks of store_queue at DW=32 and DW=64
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_store_queue;
   import store_queue_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [2:0]  in_mode;
   logic        m_ready;

   logic        a_in_ready, a_ades, a_m_valid, a_full, a_empty;
   logic [31:0] a_m_addr, a_m_data;
   logic [3:0]  a_m_be;
   logic [2:0]  a_count;

   logic        b_in_ready, b_ades, b_m_valid, b_full, b_empty;
   logic [31:0] b_m_addr;
   logic [63:0] b_m_data;
   logic [7:0]  b_m_be;
   logic [2:0]  b_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   store_queue #(.DW(32), .AW(32), .DEPTH(4), .COALESCE(1)) dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_addr(in_addr), .in_data(in_data), .in_mode(in_mode), .ades(a_ades),
      .m_valid(a_m_valid), .m_ready(m_ready), .m_addr(a_m_addr), .m_data(a_m_data),
      .m_be(a_m_be), .count(a_count), .full(a_full), .empty(a_empty)
   );

   store_queue #(.DW(64), .AW(32), .DEPTH(4), .COALESCE(1)) dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_addr(in_addr), .in_data(in_data), .in_mode(in_mode), .ades(b_ades),
      .m_valid(b_m_valid), .m_ready(m_ready), .m_addr(b_m_addr), .m_data(b_m_data),
      .m_be(b_m_be), .count(b_count), .full(b_full), .empty(b_empty)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      m_ready  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic push(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] mode);
      in_addr  = addr;
      in_data  = data;
      in_mode  = mode;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      in_addr = '0;
      in_data = '0;
      in_mode = SL_WORD;
      do_reset();
      check("rst_m_valid", a_m_valid, 0);
      check("rst_empty",   a_empty, 1);
      check("rst_full",    a_full, 0);
      check("rst_count",   a_count, 0);
      check("rst_ades",    a_ades, 0);
      check("rst_m_data",  a_m_data, 0);
      check("rst_m_be",    a_m_be, 0);

      // sw visible one cycle after acceptance
      push(32'h1000, 32'hDEADBEEF, SL_WORD);
      check("sw_m_valid", a_m_valid, 1);
      check("sw_m_addr",  a_m_addr, 32'h1000);
      check("sw_m_data",  a_m_data, 32'hDEADBEEF);
      check("sw_m_be",    a_m_be, 4'b1111);
      check("sw_count",   a_count, 1);

      // two byte stores to one word coalesce
      do_reset();
      push(32'h2003, 32'h000000AB, SL_BYTE);
      push(32'h2001, 32'h000000CD, SL_BYTE);
      check("sb_m_addr", a_m_addr, 32'h2000);
      check("sb_m_data", a_m_data, 32'hAB00CD00);
      check("sb_m_be",   a_m_be, 4'b1010);
      check("sb_count",  a_count, 1);

      // swl then swr merge to a full word
      do_reset();
      push(32'h3001, 32'h11223344, SL_WORDLEFT);
      check("swl_m_data", a_m_data, 32'h00001122);
      check("swl_m_be",   a_m_be, 4'b0011);
      push(32'h3002, 32'h11223344, SL_WORDRIGHT);
      check("swr_m_data", a_m_data, 32'h33441122);
      check("swr_m_be",   a_m_be, 4'b1111);
      check("swr_count",  a_count, 1);

      // misaligned half raises ades and is dropped
      do_reset();
      in_addr = 32'h4001; in_data = 32'h1234; in_mode = SL_HALF; in_valid = 1'b1;
      #1;
      check("mis_ades",     a_ades, 1);
      check("mis_in_ready", a_in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("mis_m_valid", a_m_valid, 0);
      check("mis_count",   a_count, 0);
      in_addr = 32'h4000; in_mode = 3'd7; in_valid = 1'b1;
      #1;
      check("undef_ades", a_ades, 0);
      tick();
      in_valid = 1'b0;
      check("undef_count", a_count, 0);

      // fill, drain with wrap, reset mid-drain
      do_reset();
      push(32'h10, 32'h1, SL_WORD);
      push(32'h20, 32'h2, SL_WORD);
      push(32'h30, 32'h3, SL_WORD);
      push(32'h40, 32'h4, SL_WORD);
      check("fill_full",  a_full, 1);
      check("fill_count", a_count, 4);
      in_addr = 32'h50; in_data = 32'h5; in_mode = SL_WORD; in_valid = 1'b1; m_ready = 1'b1;
      #1;
      check("fill_in_ready", a_in_ready, 0);
      tick();
      check("pop1_count",    a_count, 3);
      check("pop1_m_addr",   a_m_addr, 32'h20);
      check("pop1_in_ready", a_in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("pushpop_count", a_count, 3);
      check("pushpop_addr",  a_m_addr, 32'h30);
      tick();
      check("pop3_count", a_count, 2);
      check("pop3_addr",  a_m_addr, 32'h40);
      tick();
      check("wrap_count", a_count, 1);
      check("wrap_addr",  a_m_addr, 32'h50);
      check("wrap_data",  a_m_data, 32'h5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_ready = 1'b0;
      check("midrst_count",   a_count, 0);
      check("midrst_m_valid", a_m_valid, 0);
      check("midrst_m_addr",  a_m_addr, 0);

      // no merge into a lone head that is popping this cycle
      push(32'h60, 32'h11111111, SL_WORD);
      in_addr = 32'h60; in_data = 32'h22; in_mode = SL_BYTE; in_valid = 1'b1; m_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      m_ready  = 1'b0;
      check("nomerge_count", a_count, 1);
      check("nomerge_be",    a_m_be, 4'b0001);
      check("nomerge_data",  a_m_data, 32'h00000022);

      // 64-bit lane placement
      do_reset();
      push(32'h5004, 32'hCAFEF00D, SL_WORD);
      check("dw64_m_addr", b_m_addr, 32'h5000);
      check("dw64_m_data", b_m_data, 64'hCAFEF00D_00000000);
      check("dw64_m_be",   b_m_be, 8'hF0);
      check("dw32_m_addr", a_m_addr, 32'h5004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
